phase_sequencer: RTL and testbench

- Parametrised multicycle instruction phase sequencer; generalises the fixed 5-phase + 1 dead-cycle control counter.
- Emits one-hot phase enables (fetch/decode/execute/memory/writeback by default) to the datapath.
- Adds per-phase ready handshake (stall), per-instruction phase skipping decided at decode, a configurable inter-instruction gap, halt/start control, and a retired-instruction counter.

---
 rtl/cpu_ctrl_pkg.sv | 30 +++
 rtl/phase_next_sel.sv | 27 ++
 rtl/phase_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_phase_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle instruction control path:
// sequencer state encoding, default phase indices and a ceil-log2 helper.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_t;

    localparam int PH_FETCH     = 0;
    localparam int PH_DECODE    = 1;
    localparam int PH_EXECUTE   = 2;
    localparam int PH_MEMORY    = 3;
    localparam int PH_WRITEBACK = 4;

    // Ceiling log2, never less than 1 so it can size a bus directly.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/phase_next_sel.sv
// Combinational priority search: lowest phase index strictly above i_cur
// whose skip bit is clear. o_valid=0 means i_cur was the last phase.
module phase_next_sel
    import cpu_ctrl_pkg::*;
#(
    parameter int NPHASE = 5,
    parameter int IDX_W  = 3
) (
    input  logic [IDX_W-1:0]  i_cur,
    input  logic [NPHASE-1:0] i_skip,
    output logic              o_valid,
    output logic [IDX_W-1:0]  o_idx
);

    // Walk downwards so the lowest qualifying index is the one left standing.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int q = NPHASE - 1; q >= 0; q--) begin
            if ((q > int'(i_cur)) && !i_skip[q]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(q);
            end
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// Multicycle instruction phase sequencer. Steps one-hot phase enables with a
// per-phase ready handshake, skips phases chosen at decode, inserts a dead gap
// between instructions, supports halt/start and counts retired instructions.
module phase_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int NPHASE     = 5,
    parameter int DEC_IDX    = 1,
    parameter int GAP_CYCLES = 1,
    parameter int AUTO_START = 1,
    parameter int CNT_W      = 16,
    localparam int IDX_W     = clog2(NPHASE)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              halt_req,
    input  logic [NPHASE-1:0] phase_ready,
    input  logic [NPHASE-1:0] skip_mask,
    output logic [NPHASE-1:0] phase_onehot,
    output logic [IDX_W-1:0]  phase_idx,
    output logic              phase_first,
    output logic              instr_done,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    // Illegal parameter combinations stop elaboration.
    if (NPHASE < 2) begin : g_err_nphase
        $error("phase_sequencer: NPHASE must be at least 2");
    end
    if ((DEC_IDX < 0) || (DEC_IDX >= NPHASE - 1)) begin : g_err_dec
        $error("phase_sequencer: DEC_IDX must be in 0..NPHASE-2");
    end
    if ((GAP_CYCLES < 0) || (GAP_CYCLES > 15)) begin : g_err_gap
        $error("phase_sequencer: GAP_CYCLES must be in 0..15");
    end
    if ((AUTO_START != 0) && (AUTO_START != 1)) begin : g_err_auto
        $error("phase_sequencer: AUTO_START must be 0 or 1");
    end
    if (CNT_W < 1) begin : g_err_cnt
        $error("phase_sequencer: CNT_W must be at least 1");
    end

    localparam seq_state_t        RST_STATE  = (AUTO_START != 0) ? ST_RUN : ST_IDLE;
    localparam logic [NPHASE-1:0] ONEHOT_P0  = NPHASE'(1);
    localparam logic [NPHASE-1:0] RST_ONEHOT = (AUTO_START != 0) ? ONEHOT_P0 : '0;
    localparam logic              RST_FIRST  = (AUTO_START != 0);
    localparam logic [IDX_W-1:0]  DEC_PH     = IDX_W'(DEC_IDX);
    localparam logic [3:0]        GAP_LOAD   = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    seq_state_t        r_state, r_state_next;
    logic [IDX_W-1:0]  r_phase, r_phase_next;
    logic [NPHASE-1:0] r_onehot, r_onehot_next;
    logic              r_first, r_first_next;
    logic              r_done, r_done_next;
    logic              r_halted, r_halted_next;
    logic [CNT_W-1:0]  r_count, r_count_next;
    logic [NPHASE-1:0] r_skip, r_skip_next;
    logic [3:0]        r_gap, r_gap_next;

    logic [NPHASE-1:0] w_keep;
    logic [NPHASE-1:0] w_eff_skip;
    logic              w_nxt_valid;
    logic [IDX_W-1:0]  w_nxt_idx;

    // Only skip bits above the decode phase may take effect.
    for (genvar gi = 0; gi < NPHASE; gi++) begin : g_keep
        assign w_keep[gi] = (gi > DEC_IDX);
    end

    // Effective skip set: live mask while leaving decode, latched copy after it.
    always_comb begin
        w_eff_skip = '0;
        if (r_phase == DEC_PH) begin
            w_eff_skip = skip_mask & w_keep;
        end else if (r_phase > DEC_PH) begin
            w_eff_skip = r_skip;
        end
    end

    phase_next_sel #(
        .NPHASE (NPHASE),
        .IDX_W  (IDX_W)
    ) u_next_sel (
        .i_cur   (r_phase),
        .i_skip  (w_eff_skip),
        .o_valid (w_nxt_valid),
        .o_idx   (w_nxt_idx)
    );

    // Next-state and next-output logic; every output is taken from a register.
    always_comb begin
        r_state_next  = r_state;
        r_phase_next  = r_phase;
        r_onehot_next = r_onehot;
        r_first_next  = 1'b0;
        r_done_next   = 1'b0;
        r_count_next  = r_count;
        r_skip_next   = r_skip;
        r_gap_next    = r_gap;

        case (r_state)
            ST_IDLE: begin
                // Halt wins when both are requested.
                if (start && !halt_req) begin
                    r_state_next  = ST_RUN;
                    r_phase_next  = '0;
                    r_onehot_next = ONEHOT_P0;
                    r_first_next  = 1'b1;
                    r_skip_next   = '0;
                end
            end

            ST_RUN: begin
                if (phase_ready[r_phase]) begin
                    if (r_phase == DEC_PH) begin
                        r_skip_next = w_eff_skip;
                    end
                    if (w_nxt_valid) begin
                        r_phase_next  = w_nxt_idx;
                        r_onehot_next = ONEHOT_P0 << w_nxt_idx;
                        r_first_next  = 1'b1;
                    end else begin
                        // Instruction boundary: retire, then halt, gap or refetch.
                        r_done_next   = 1'b1;
                        r_count_next  = r_count + CNT_W'(1);
                        r_phase_next  = '0;
                        r_onehot_next = '0;
                        if (halt_req) begin
                            r_state_next = ST_IDLE;
                        end else if (GAP_CYCLES > 0) begin
                            r_state_next = ST_GAP;
                            r_gap_next   = GAP_LOAD;
                        end else begin
                            r_onehot_next = ONEHOT_P0;
                            r_first_next  = 1'b1;
                            r_skip_next   = '0;
                        end
                    end
                end
            end

            ST_GAP: begin
                if (r_gap == 4'd0) begin
                    r_state_next  = ST_RUN;
                    r_phase_next  = '0;
                    r_onehot_next = ONEHOT_P0;
                    r_first_next  = 1'b1;
                    r_skip_next   = '0;
                end else begin
                    r_gap_next = r_gap - 4'd1;
                end
            end

            default: begin
                r_state_next  = ST_IDLE;
                r_phase_next  = '0;
                r_onehot_next = '0;
            end
        endcase

        r_halted_next = (r_state_next == ST_IDLE);
    end

    // State and output registers; reset abandons any in-flight instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= RST_STATE;
            r_phase  <= '0;
            r_onehot <= RST_ONEHOT;
            r_first  <= RST_FIRST;
            r_done   <= 1'b0;
            r_halted <= (AUTO_START == 0);
            r_count  <= '0;
            r_skip   <= '0;
            r_gap    <= 4'd0;
        end else begin
            r_state  <= r_state_next;
            r_phase  <= r_phase_next;
            r_onehot <= r_onehot_next;
            r_first  <= r_first_next;
            r_done   <= r_done_next;
            r_halted <= r_halted_next;
            r_count  <= r_count_next;
            r_skip   <= r_skip_next;
            r_gap    <= r_gap_next;
        end
    end

    assign phase_onehot = r_onehot;
    assign phase_idx    = r_phase;
    assign phase_first  = r_first;
    assign instr_done   = r_done;
    assign halted       = r_halted;
    assign instr_count  = r_count;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: default 5-phase build plus a 3-phase,
// gapless build with auto-start and a halted-at-reset variant of it.
module tb_phase_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Default configuration
    logic        rst = 1'b1, start = 1'b0, halt_req = 1'b0;
    logic [4:0]  ready = 5'b11111, skip = 5'b00000;
    logic [4:0]  oh;
    logic [2:0]  idx;
    logic        first, done, halted;
    logic [15:0] count;

    // NPHASE=3, gapless, 2-bit counter
    logic        rst_s = 1'b1;
    logic        start_s = 1'b0, halt_s = 1'b0;
    logic [2:0]  ready_s = 3'b111, skip_s = 3'b000;
    logic [2:0]  oh_s;
    logic [1:0]  idx_s;
    logic        first_s, done_s, halted_s;
    logic [1:0]  count_s;

    // Same, but leaves reset halted
    logic        rst_h = 1'b1, start_h = 1'b0;
    logic [2:0]  oh_h;
    logic [1:0]  idx_h;
    logic        first_h, done_h, halted_h;
    logic [1:0]  count_h;

    phase_sequencer u_dut (
        .clk(clk), .reset(rst), .start(start), .halt_req(halt_req),
        .phase_ready(ready), .skip_mask(skip),
        .phase_onehot(oh), .phase_idx(idx), .phase_first(first),
        .instr_done(done), .halted(halted), .instr_count(count)
    );

    phase_sequencer #(.NPHASE(3), .DEC_IDX(1), .GAP_CYCLES(0), .AUTO_START(1), .CNT_W(2)) u_small (
        .clk(clk), .reset(rst_s), .start(start_s), .halt_req(halt_s),
        .phase_ready(ready_s), .skip_mask(skip_s),
        .phase_onehot(oh_s), .phase_idx(idx_s), .phase_first(first_s),
        .instr_done(done_s), .halted(halted_s), .instr_count(count_s)
    );

    phase_sequencer #(.NPHASE(3), .DEC_IDX(1), .GAP_CYCLES(0), .AUTO_START(0), .CNT_W(2)) u_idle (
        .clk(clk), .reset(rst_h), .start(start_h), .halt_req(halt_s),
        .phase_ready(ready_s), .skip_mask(skip_s),
        .phase_onehot(oh_h), .phase_idx(idx_h), .phase_first(first_h),
        .instr_done(done_h), .halted(halted_h), .instr_count(count_h)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full unskipped, unstalled instruction starting in fetch.
    task automatic run_full(input string tag, input int cnt_exp);
        logic [4:0] exp_oh [6];
        exp_oh = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00000};
        for (int c = 0; c < 6; c++) begin
            check({tag, "_oh"}, oh, exp_oh[c]);
            if (c == 5) begin
                check({tag, "_done"}, done, 1);
                check({tag, "_cnt"}, count, cnt_exp);
            end
            tick();
        end
    endtask

    initial begin
        // Reset state, default build
        tick();
        tick();
        check("rst_oh", oh, 5'b00001);
        check("rst_idx", idx, 0);
        check("rst_first", first, 1);
        check("rst_halted", halted, 0);
        check("rst_done", done, 0);
        check("rst_cnt", count, 0);
        rst = 1'b0;

        // 1: legacy 6-cycle period
        check("t1_first", first, 1);
        run_full("t1a", 1);
        run_full("t1b", 2);
        run_full("t1c", 3);

        // 2: skip memory, decided at decode; live mask cleared afterwards
        skip = 5'b01000;
        check("t2_oh_f", oh, 5'b00001);
        tick();
        check("t2_oh_d", oh, 5'b00010);
        check("t2_idx_d", idx, 1);
        tick();
        skip = 5'b00000;
        check("t2_oh_e", oh, 5'b00100);
        tick();
        check("t2_oh_wb", oh, 5'b10000);
        check("t2_first_wb", first, 1);
        check("t2_idx_wb", idx, 4);
        tick();
        check("t2_oh_gap", oh, 5'b00000);
        check("t2_cnt", count, 4);
        tick();
        run_full("t2n", 5);

        // 3: memory stalls three cycles
        check("t3_oh_f", oh, 5'b00001);
        tick();
        tick();
        tick();
        ready = 5'b10111;
        check("t3_oh_m1", oh, 5'b01000);
        check("t3_first_m1", first, 1);
        tick();
        check("t3_oh_m2", oh, 5'b01000);
        check("t3_first_m2", first, 0);
        tick();
        check("t3_oh_m3", oh, 5'b01000);
        tick();
        ready = 5'b11111;
        check("t3_oh_m4", oh, 5'b01000);
        check("t3_first_m4", first, 0);
        tick();
        check("t3_oh_wb", oh, 5'b10000);
        check("t3_first_wb", first, 1);
        tick();
        check("t3_cnt", count, 6);
        tick();

        // 4: halt at boundary, start, start+halt in IDLE
        tick();
        tick();
        tick();
        tick();
        check("t4_oh_wb", oh, 5'b10000);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("t4_halted", halted, 1);
        check("t4_oh", oh, 5'b00000);
        check("t4_done", done, 1);
        check("t4_cnt", count, 7);
        tick();
        check("t4_still_halted", halted, 1);
        check("t4_done_off", done, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_start_oh", oh, 5'b00001);
        check("t4_start_first", first, 1);
        check("t4_start_halted", halted, 0);
        tick();
        tick();
        tick();
        tick();
        halt_req = 1'b1;
        tick();
        check("t4_halt2", halted, 1);
        check("t4_cnt2", count, 8);
        start = 1'b1;
        tick();
        tick();
        check("t4_both_halted", halted, 1);
        check("t4_both_oh", oh, 5'b00000);
        halt_req = 1'b0;
        tick();
        start = 1'b0;
        check("t4_restart_oh", oh, 5'b00001);

        // 5: async reset mid-execute with a latched skip
        skip = 5'b01000;
        tick();
        tick();
        skip = 5'b00000;
        check("t5_oh_e", oh, 5'b00100);
        #3;
        rst = 1'b1;
        #1;
        check("t5_async_oh", oh, 5'b00001);
        check("t5_async_first", first, 1);
        check("t5_async_cnt", count, 0);
        check("t5_async_idx", idx, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_full("t5n", 1);

        // 6: NPHASE=3, no gap, 2-bit wrapping counter
        rst_s = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 3; c++) begin
                check("t6_oh", oh_s, 3'b001 << c);
                if (c == 0) begin
                    check("t6_cnt", count_s, k % 4);
                    check("t6_done", done_s, (k > 0) ? 1 : 0);
                end
                tick();
            end
        end
        check("t6_wrap_cnt", count_s, 0);
        check("t6_wrap_done", done_s, 1);
        check("t6_wrap_first", first_s, 1);

        // 6b: AUTO_START=0 stays halted until start
        check("t6h_rst_halted", halted_h, 1);
        rst_h = 1'b0;
        tick();
        tick();
        check("t6h_halted", halted_h, 1);
        check("t6h_oh", oh_h, 3'b000);
        check("t6h_first", first_h, 0);
        start_h = 1'b1;
        tick();
        start_h = 1'b0;
        check("t6h_start_oh", oh_h, 3'b001);
        check("t6h_start_first", first_h, 1);
        check("t6h_start_halted", halted_h, 0);
        tick();
        check("t6h_dec_oh", oh_h, 3'b010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
